// File: rtl/matmul_weight_replay_buffer.sv
// Weight-tile replay buffer feeding the matmul core's data_in2 port: the first pass
// of a tile streams straight through while it is captured, then it is replayed REPEAT-1 times.
module matmul_weight_replay_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int BLOCK_SIZE = 15,
   parameter int DEPTH      = 3,
   parameter int REPEAT     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in [BLOCK_SIZE-1:0],
   input  logic                  data_in_valid,
   output logic                  data_in_ready,
   output logic [DATA_WIDTH-1:0] data_out [BLOCK_SIZE-1:0],
   output logic                  data_out_valid,
   input  logic                  data_out_ready
);

   localparam int BW = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
   localparam int PW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(DEPTH - 1);
   localparam logic [PW-1:0] LAST_PASS = PW'(REPEAT - 1);

   localparam logic [0:0] S_FILL   = 1'b0;
   localparam logic [0:0] S_REPLAY = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
   logic [PW-1:0]         pass_cnt_q, pass_cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH-1:0][BLOCK_SIZE-1:0];
   logic                  fill;
   logic                  xfer;

   assign fill = (state_q == S_FILL);

   // FILL is a pure combinational bypass; ready never depends on valid, so no loop.
   always_comb begin
      data_in_ready  = fill ? data_out_ready : 1'b0;
      data_out_valid = fill ? data_in_valid  : 1'b1;
      for (int i = 0; i < BLOCK_SIZE; i++)
         data_out[i] = fill ? data_in[i] : mem_q[beat_cnt_q][i];
      if (rst) begin
         data_in_ready  = 1'b0;
         data_out_valid = 1'b0;
      end
   end

   // In FILL an output transfer is also the input transfer.
   assign xfer = data_out_valid && data_out_ready;

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      pass_cnt_d = pass_cnt_q;
      if (xfer) begin
         if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            if (fill) begin
               if (REPEAT > 1) begin
                  state_d    = S_REPLAY;
                  pass_cnt_d = PW'(1);
               end
            end else if (pass_cnt_q == LAST_PASS) begin
               state_d    = S_FILL;
               pass_cnt_d = '0;
            end else begin
               pass_cnt_d = pass_cnt_q + 1'b1;
            end
         end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FILL;
         beat_cnt_q <= '0;
         pass_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         pass_cnt_q <= pass_cnt_d;
      end
   end

   // Tile storage is deliberately not reset; it is always rewritten before being replayed.
   always_ff @(posedge clk) begin
      if (fill && xfer) begin
         for (int i = 0; i < BLOCK_SIZE; i++)
            mem_q[beat_cnt_q][i] <= data_in[i];
      end
   end

endmodule

// File: tb/tb_matmul_weight_replay_buffer.sv
// Directed bench for matmul_weight_replay_buffer: default geometry plus a REPEAT=1
// pass-through instance and a DEPTH=1 instance.
module tb_matmul_weight_replay_buffer;

   localparam int DW = 16;
   localparam int BS = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // default instance (DEPTH=3, REPEAT=4)
   logic [DW-1:0] a_din  [BS-1:0];
   logic [DW-1:0] a_dout [BS-1:0];
   logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   // DEPTH=2, REPEAT=1
   logic [DW-1:0] r_din  [BS-1:0];
   logic [DW-1:0] r_dout [BS-1:0];
   logic r_in_valid, r_in_ready, r_out_valid, r_out_ready;
   // DEPTH=1, REPEAT=3
   logic [DW-1:0] d_din  [BS-1:0];
   logic [DW-1:0] d_dout [BS-1:0];
   logic d_in_valid, d_in_ready, d_out_valid, d_out_ready;

   int n_tests = 0;
   int n_fail  = 0;

   matmul_weight_replay_buffer #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS), .DEPTH(3), .REPEAT(4)) u_dut (
      .clk(clk), .rst(rst), .data_in(a_din), .data_in_valid(a_in_valid), .data_in_ready(a_in_ready),
      .data_out(a_dout), .data_out_valid(a_out_valid), .data_out_ready(a_out_ready));

   matmul_weight_replay_buffer #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS), .DEPTH(2), .REPEAT(1)) u_r1 (
      .clk(clk), .rst(rst), .data_in(r_din), .data_in_valid(r_in_valid), .data_in_ready(r_in_ready),
      .data_out(r_dout), .data_out_valid(r_out_valid), .data_out_ready(r_out_ready));

   matmul_weight_replay_buffer #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS), .DEPTH(1), .REPEAT(3)) u_d1 (
      .clk(clk), .rst(rst), .data_in(d_din), .data_in_valid(d_in_valid), .data_in_ready(d_in_ready),
      .data_out(d_dout), .data_out_valid(d_out_valid), .data_out_ready(d_out_ready));

   function automatic logic [DW*BS-1:0] pk(input logic [DW-1:0] a [BS-1:0]);
      logic [DW*BS-1:0] r;
      for (int i = 0; i < BS; i++) r[i*DW +: DW] = a[i];
      return r;
   endfunction

   // lane i = base + i*step
   function automatic logic [DW*BS-1:0] pat(input int base, input int step);
      logic [DW*BS-1:0] r;
      for (int i = 0; i < BS; i++) r[i*DW +: DW] = DW'(base + i * step);
      return r;
   endfunction

   task automatic drive_a(input int base, input int step);
      for (int i = 0; i < BS; i++) a_din[i] = DW'(base + i * step);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_in_valid = 1'b1; a_out_ready = 1'b1;
      r_in_valid = 1'b1; r_out_ready = 1'b1;
      d_in_valid = 1'b1; d_out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_a: valid=%b ready=%b required 0 0", a_out_valid, a_in_ready);
      end
      n_tests++;
      if (r_out_valid !== 1'b0 || r_in_ready !== 1'b0 || d_out_valid !== 1'b0 || d_in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_rd: r %b%b d %b%b required 00 00", r_out_valid, r_in_ready, d_out_valid, d_in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      a_in_valid = 1'b0; r_in_valid = 1'b0; d_in_valid = 1'b0;
   endtask

   // Checks a full 3-beat tile (bases b0, b0+15, b0+30) replayed 3 more times, starting
   // from the negedge after the last FILL beat was presented.
   task automatic fill_and_replay(input string nm, input int b0);
      a_out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         a_in_valid = 1'b1; drive_a(b0 + 15 * k, 1);
         @(negedge clk);
         n_tests++;
         if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1 || pk(a_dout) !== pat(b0 + 15 * k, 1)) begin
            n_fail++; $display("FAIL %s_fill%0d: v=%b r=%b out=%h required v=1 r=1 out=%h",
                               nm, k, a_out_valid, a_in_ready, pk(a_dout), pat(b0 + 15 * k, 1));
         end
      end
      @(posedge clk); #1;
      a_in_valid = 1'b0; drive_a(16'hDEAD, 0);
      for (int n = 0; n < 9; n++) begin
         @(negedge clk);
         n_tests++;
         if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || pk(a_dout) !== pat(b0 + 15 * (n % 3), 1)) begin
            n_fail++; $display("FAIL %s_replay%0d: v=%b r=%b out=%h required v=1 r=0 out=%h",
                               nm, n, a_out_valid, a_in_ready, pk(a_dout), pat(b0 + 15 * (n % 3), 1));
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_tests++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         n_fail++; $display("FAIL %s_refill: ready=%b valid=%b required 1 0", nm, a_in_ready, a_out_valid);
      end
   endtask

   task automatic test_replay_basic();
      fill_and_replay("basic", 1);
   endtask

   task automatic test_backpressure();
      int got;
      int cyc;
      a_out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         a_in_valid = 1'b1; drive_a(101 + 15 * k, 1);
         @(negedge clk);
         n_tests++;
         if (pk(a_dout) !== pat(101 + 15 * k, 1) || a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_fill%0d: out=%h r=%b required %h 1", k, pk(a_dout), a_in_ready, pat(101 + 15 * k, 1));
         end
      end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      got = 0; cyc = 0;
      while (got < 9 && cyc < 200) begin
         a_out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_tests++;
         if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || pk(a_dout) !== pat(101 + 15 * (got % 3), 1)) begin
            n_fail++; $display("FAIL bp_beat%0d: v=%b r=%b out=%h required v=1 r=0 out=%h",
                               got, a_out_valid, a_in_ready, pk(a_dout), pat(101 + 15 * (got % 3), 1));
         end
         if (a_out_ready) got++;
         cyc++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (got != 9) begin
         n_fail++; $display("FAIL bp_timeout: beats=%0d required 9", got);
      end
      a_out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_end: ready=%b valid=%b required 1 0", a_in_ready, a_out_valid);
      end
   endtask

   task automatic test_passthrough();
      logic [5:0] vseq;
      int v;
      vseq = 6'b110111;  // bubble in the middle of the beat stream
      v = 10;
      r_out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         r_in_valid = vseq[c];
         for (int i = 0; i < BS; i++) r_din[i] = vseq[c] ? DW'(v) : 16'h5555;
         @(negedge clk);
         n_tests++;
         if (r_out_valid !== vseq[c] || r_in_ready !== 1'b1 || (vseq[c] && pk(r_dout) !== pat(v, 0))) begin
            n_fail++; $display("FAIL pt_cyc%0d: v=%b r=%b out=%h required v=%b r=1 out=%h",
                               c, r_out_valid, r_in_ready, pk(r_dout), vseq[c], pat(v, 0));
         end
         if (vseq[c]) v++;
      end
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         r_in_valid = 1'b1;
         for (int i = 0; i < BS; i++) r_din[i] = DW'(v);
         r_out_ready = (c == 1);
         @(negedge clk);
         n_tests++;
         if (r_out_valid !== 1'b1 || r_in_ready !== r_out_ready || pk(r_dout) !== pat(v, 0)) begin
            n_fail++; $display("FAIL pt_tail%0d: v=%b r=%b out=%h required v=1 r=%b out=%h",
                               c, r_out_valid, r_in_ready, pk(r_dout), r_out_ready, pat(v, 0));
         end
      end
      @(posedge clk); #1;
      r_in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (r_out_valid !== 1'b0 || r_in_ready !== 1'b1) begin
         n_fail++; $display("FAIL pt_idle: v=%b r=%b required 0 1", r_out_valid, r_in_ready);
      end
   endtask

   task automatic test_reset_mid();
      a_out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         a_in_valid = 1'b1; drive_a(1 + 15 * k, 1);
      end
      @(posedge clk); #1;   // third fill beat transferred
      a_in_valid = 1'b0;
      @(posedge clk); #1;   // replay beat 4 transferred
      @(posedge clk); #1;   // replay beat 5 transferred
      rst = 1'b1;
      a_in_valid = 1'b1; drive_a(16'h7777, 0);
      @(negedge clk);
      n_tests++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_hold: v=%b r=%b required 0 0", a_out_valid, a_in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      a_in_valid = 1'b0;
      fill_and_replay("rstmid", 201);
   endtask

   task automatic test_depth1();
      d_out_ready = 1'b1;
      @(posedge clk); #1;
      d_in_valid = 1'b1;
      for (int i = 0; i < BS; i++) d_din[i] = 16'h0007;
      @(negedge clk);
      n_tests++;
      if (d_out_valid !== 1'b1 || d_in_ready !== 1'b1 || pk(d_dout) !== pat(7, 0)) begin
         n_fail++; $display("FAIL d1_fill: v=%b r=%b out=%h required 1 1 %h", d_out_valid, d_in_ready, pk(d_dout), pat(7, 0));
      end
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      for (int i = 0; i < BS; i++) d_din[i] = 16'h0009;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         n_tests++;
         if (d_out_valid !== 1'b1 || d_in_ready !== 1'b0 || pk(d_dout) !== pat(7, 0)) begin
            n_fail++; $display("FAIL d1_replay%0d: v=%b r=%b out=%h required 1 0 %h", n, d_out_valid, d_in_ready, pk(d_dout), pat(7, 0));
         end
         @(posedge clk); #1;
      end
      d_in_valid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (d_in_ready !== 1'b1 || pk(d_dout) !== pat(9, 0)) begin
         n_fail++; $display("FAIL d1_next: r=%b out=%h required 1 %h", d_in_ready, pk(d_dout), pat(9, 0));
      end
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      d_out_ready = 1'b0;   // park the instance in REPLAY, stalled
   endtask

   task automatic test_bubbles();
      logic [4:0] vseq;
      int k;
      vseq = 5'b11001;
      k = 0;
      a_out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         a_in_valid = vseq[c];
         if (vseq[c]) drive_a(301 + 15 * k, 1); else drive_a(16'hFFFF, 0);
         @(negedge clk);
         n_tests++;
         if (a_out_valid !== vseq[c] || a_in_ready !== 1'b1 || (vseq[c] && pk(a_dout) !== pat(301 + 15 * k, 1))) begin
            n_fail++; $display("FAIL bub_cyc%0d: v=%b r=%b out=%h required v=%b r=1 out=%h",
                               c, a_out_valid, a_in_ready, pk(a_dout), vseq[c], pat(301 + 15 * k, 1));
         end
         if (vseq[c]) k++;
      end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      for (int n = 0; n < 9; n++) begin
         @(negedge clk);
         n_tests++;
         if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || pk(a_dout) !== pat(301 + 15 * (n % 3), 1)) begin
            n_fail++; $display("FAIL bub_replay%0d: v=%b r=%b out=%h required v=1 r=0 out=%h",
                               n, a_out_valid, a_in_ready, pk(a_dout), pat(301 + 15 * (n % 3), 1));
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_tests++;
      if (a_in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bub_end: ready=%b required 1", a_in_ready);
      end
   endtask

   initial begin
      for (int i = 0; i < BS; i++) begin
         a_din[i] = '0; r_din[i] = '0; d_din[i] = '0;
      end
      a_in_valid = 1'b0; a_out_ready = 1'b0;
      r_in_valid = 1'b0; r_out_ready = 1'b0;
      d_in_valid = 1'b0; d_out_ready = 1'b0;
      test_reset();
      test_replay_basic();
      test_backpressure();
      test_passthrough();
      test_reset_mid();
      test_depth1();
      test_bubbles();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
